// File: rtl/riscv_dmem_arb_pkg.sv
// rtl/riscv_dmem_arb_pkg.sv - shared config, FSM encoding and helpers for the dmem arbiter
package riscv_dmem_arb_pkg;

    localparam int CFG_XLEN          = 32;
    localparam int CFG_DMEM_ADDR_BIT = 12;
    localparam int CFG_STARVE_LIMIT  = 4;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_LOCK1 = 1'b1
    } arb_state_t;

    // Counter must be able to hold the value STARVE_LIMIT itself.
    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/riscv_dmem_arb_resp.sv
// rtl/riscv_dmem_arb_resp.sv - per-port read response register (1-cycle rvalid, held rdata)
module riscv_dmem_arb_resp
    import riscv_dmem_arb_pkg::*;
#(
    parameter int XLEN = CFG_XLEN
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_capture,
    input  logic [XLEN-1:0] i_data,
    output logic            o_rvalid,
    output logic [XLEN-1:0] o_rdata
);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_rvalid <= 1'b0;
            o_rdata  <= '0;
        end else begin
            o_rvalid <= i_capture;
            if (i_capture) begin
                o_rdata <= i_data;
            end
        end
    end

endmodule

// File: rtl/riscv_dmem_arb.sv
// rtl/riscv_dmem_arb.sv - two-port dmem arbiter with port-1 starvation bound and lock
module riscv_dmem_arb
    import riscv_dmem_arb_pkg::*;
#(
    parameter int XLEN          = CFG_XLEN,
    parameter int DMEM_ADDR_BIT = CFG_DMEM_ADDR_BIT,
    parameter int STARVE_LIMIT  = CFG_STARVE_LIMIT
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_p0_req,
    input  logic                     i_p0_wr,
    input  logic [XLEN/8-1:0]        i_p0_byte_sel,
    input  logic [DMEM_ADDR_BIT-3:0] i_p0_addr,
    input  logic [XLEN-1:0]          i_p0_wdata,
    output logic                     o_p0_gnt,
    output logic                     o_p0_rvalid,
    output logic [XLEN-1:0]          o_p0_rdata,
    input  logic                     i_p1_req,
    input  logic                     i_p1_wr,
    input  logic [XLEN/8-1:0]        i_p1_byte_sel,
    input  logic [DMEM_ADDR_BIT-3:0] i_p1_addr,
    input  logic [XLEN-1:0]          i_p1_wdata,
    output logic                     o_p1_gnt,
    output logic                     o_p1_rvalid,
    output logic [XLEN-1:0]          o_p1_rdata,
    input  logic                     i_p1_lock,
    output logic                     o_dmem_wr_en,
    output logic [XLEN/8-1:0]        o_dmem_byte_sel,
    output logic [DMEM_ADDR_BIT-3:0] o_dmem_addr,
    output logic [XLEN-1:0]          o_dmem_data,
    input  logic [XLEN-1:0]          i_dmem_data
);

    localparam int CW = cnt_width(STARVE_LIMIT);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          gnt0, gnt1;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= ST_ARB;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        starve_d = '0;
        state_d  = ST_ARB;
        case (state_q)
            ST_LOCK1: begin
                gnt1 = i_p1_req;
            end
            default: begin
                if (i_p0_req && i_p1_req) begin
                    gnt1 = (starve_q == LIMIT);
                    gnt0 = !gnt1;
                end else begin
                    gnt0 = i_p0_req;
                    gnt1 = i_p1_req;
                end
                // Only a contested p0 win counts towards forcing port 1.
                if (gnt0 && i_p1_req) begin
                    starve_d = (starve_q == LIMIT) ? starve_q : starve_q + CW'(1);
                end
            end
        endcase
        if (i_p1_lock && (gnt1 || state_q == ST_LOCK1)) begin
            state_d = ST_LOCK1;
        end
    end

    assign o_p0_gnt = gnt0;
    assign o_p1_gnt = gnt1;

    always_comb begin
        o_dmem_wr_en    = 1'b0;
        o_dmem_byte_sel = '0;
        o_dmem_addr     = '0;
        o_dmem_data     = '0;
        if (gnt0) begin
            o_dmem_wr_en    = i_p0_wr;
            o_dmem_byte_sel = i_p0_wr ? i_p0_byte_sel : '0;
            o_dmem_addr     = i_p0_addr;
            o_dmem_data     = i_p0_wdata;
        end else if (gnt1) begin
            o_dmem_wr_en    = i_p1_wr;
            o_dmem_byte_sel = i_p1_wr ? i_p1_byte_sel : '0;
            o_dmem_addr     = i_p1_addr;
            o_dmem_data     = i_p1_wdata;
        end
    end

    riscv_dmem_arb_resp #(.XLEN(XLEN)) u_resp0 (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_capture (gnt0 && !i_p0_wr),
        .i_data    (i_dmem_data),
        .o_rvalid  (o_p0_rvalid),
        .o_rdata   (o_p0_rdata)
    );

    riscv_dmem_arb_resp #(.XLEN(XLEN)) u_resp1 (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_capture (gnt1 && !i_p1_wr),
        .i_data    (i_dmem_data),
        .o_rvalid  (o_p1_rvalid),
        .o_rdata   (o_p1_rdata)
    );

endmodule
